// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 responder for the ADXL362 command set
// (0x0A write register, 0x0B read register, 0x0D read FIFO).
// Pins are oversampled on clk_i; register accesses become one-cycle
// strobes on a local register bus.
// Optional build macro: SPI_REG_SLAVE_FIFO_READ_EN enables the 0x0D FIFO read.
// Without it 0x0D is an unknown command and fifo_rd_o stays low.
module spi_reg_slave #(
  parameter int AW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sclk_i,
  input  logic          mosi_i,
  input  logic          ncs_i,
  output logic          miso_o,
  output logic          miso_oe_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [7:0]    reg_wdata_o,
  output logic          reg_we_o,
  output logic          reg_re_o,
  input  logic [7:0]    reg_rdata_i,
  output logic          fifo_rd_o,
  input  logic [7:0]    fifo_data_i,
  output logic          busy_o
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, FDATA, IGNORE} state_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
`ifdef SPI_REG_SLAVE_FIFO_READ_EN
  localparam logic [7:0] CMD_FIFO  = 8'h0D;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ncs_sync;
  logic [SYNC_STAGES:0]   primed;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, mosi_s, ncs_s;
  logic                   rise, fall, ncs_fall, ready;

  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sr;
  logic [7:0]             rx_byte;
  logic                   byte_done;

  state_t                 state, state_nxt;
  logic                   is_write, wr_nxt;
  logic                   we_set, re_set, pop_set, addr_load, addr_step;

  logic [AW-1:0]          addr, next_addr, load_addr;
  logic                   re_d;
  logic [7:0]             rbuf, tx_sr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  // Edge detection is only meaningful once the chains hold real pin values
  assign ready     = primed[SYNC_STAGES];
  assign rise      = ~ncs_s & sclk_s & ~sclk_d;
  assign fall      = ~ncs_s & ~sclk_s & sclk_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign rx_byte   = {rx_sr, mosi_s};
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign next_addr = addr + AW'(1);
  assign load_addr = AW'(rx_byte);

  // Pin synchronizers plus one extra stage for sclk/ncs edge detection
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      primed    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_i};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Receive shifter and bit counter; a partial byte is dropped when ncs rises
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 7'd0;
    end else if (state == IDLE || ncs_s) begin
      bit_cnt <= 3'd0;
    end else if (rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sr   <= rx_byte[6:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      is_write <= 1'b0;
    end else begin
      state    <= state_nxt;
      is_write <= wr_nxt;
    end
  end

  // FSM next state and bus strobe requests
  always_comb begin
    state_nxt = state;
    wr_nxt    = is_write;
    we_set    = 1'b0;
    re_set    = 1'b0;
    pop_set   = 1'b0;
    addr_load = 1'b0;
    addr_step = 1'b0;
    if (state != IDLE && ncs_s) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // ncs already low without a seen falling edge (e.g. after reset): sit out
          if (ready && ncs_fall)    state_nxt = CMD;
          else if (ready && !ncs_s) state_nxt = IGNORE;
        end
        CMD: begin
          if (byte_done) begin
            case (rx_byte)
              CMD_WRITE: begin state_nxt = ADDR; wr_nxt = 1'b1; end
              CMD_READ:  begin state_nxt = ADDR; wr_nxt = 1'b0; end
`ifdef SPI_REG_SLAVE_FIFO_READ_EN
              CMD_FIFO:  begin state_nxt = FDATA; pop_set = 1'b1; end
`endif
              default:   state_nxt = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (byte_done) begin
            addr_load = 1'b1;
            if (is_write) begin
              state_nxt = WDATA;
            end else begin
              re_set    = 1'b1;
              state_nxt = RDATA;
            end
          end
        end
        WDATA: begin
          if (byte_done) we_set = 1'b1;
        end
        RDATA: begin
          // Read ahead the next address as soon as the current byte is consumed
          if (byte_done) begin
            re_set    = 1'b1;
            addr_step = 1'b1;
          end
        end
        FDATA: begin
`ifdef SPI_REG_SLAVE_FIFO_READ_EN
          if (byte_done) pop_set = 1'b1;
`endif
        end
        IGNORE: begin
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register bus strobes, address counter and write data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      fifo_rd_o   <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= 8'd0;
      addr        <= '0;
    end else begin
      reg_we_o  <= we_set;
      reg_re_o  <= re_set;
      fifo_rd_o <= pop_set;
      if (addr_load) begin
        addr       <= load_addr;
        reg_addr_o <= load_addr;
      end else if (addr_step) begin
        addr       <= next_addr;
        reg_addr_o <= next_addr;
      end else if (we_set) begin
        reg_addr_o  <= addr;
        reg_wdata_o <= rx_byte;
        addr        <= next_addr;
      end
    end
  end

`ifdef SPI_REG_SLAVE_FIFO_READ_EN
  logic pop_d;

  // Delay the FIFO pop so its data is sampled the cycle after the strobe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pop_d <= 1'b0;
    else        pop_d <= fifo_rd_o;
  end
`else
  logic unused_fifo;
  assign unused_fifo = ^fifo_data_i;
`endif

  // Capture returned data, then shift it out MSB first on sclk falling edges
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      re_d   <= 1'b0;
      rbuf   <= 8'd0;
      tx_sr  <= 8'd0;
      miso_o <= 1'b0;
    end else begin
      re_d <= reg_re_o;
      if (re_d) rbuf <= reg_rdata_i;
`ifdef SPI_REG_SLAVE_FIFO_READ_EN
      else if (pop_d) rbuf <= fifo_data_i;
`endif
      if (state != RDATA && state != FDATA) begin
        miso_o <= 1'b0;
      end else if (fall) begin
        if (bit_cnt == 3'd0) begin
          miso_o <= rbuf[7];
          tx_sr  <= {rbuf[6:0], 1'b0};
        end else begin
          miso_o <= tx_sr[7];
          tx_sr  <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  // Output enable and busy both follow the synchronized chip select
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      miso_oe_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      miso_oe_o <= ~ncs_s;
      busy_o    <= ~ncs_s;
    end
  end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
Synthesizable SPI responder that implements the ADXL362 command protocol: write register 0x0A, read register 0x0B, and read FIFO 0x0D. It is the slave-side counterpart to simple_spi_top. SPI pins are oversampled on clk_i. Register accesses are converted into single-cycle strobes on a local register bus, so a register bank or sensor core can sit behind the SPI pins. It serves as the RTL replacement for the behavioural accelerometer model in system benches.

Parameters:
AW, 8, register address width; auto-increment wraps modulo 2^AW
SYNC_STAGES, 2, synchronizer depth on sclk_i, mosi_i, ncs_i (minimum 2)

Ports:
clk_i  input  1  system clock; SPI pins oversampled on it
rst_i  input  1  asynchronous active-low reset
sclk_i  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0); f(sclk) <= f(clk_i)/8
mosi_i  input  1  master out, slave in; MSB first
ncs_i  input  1  chip select, active low
miso_o  output  1  slave out, master in
miso_oe_o  output  1  high while synchronized ncs is low
reg_addr_o  output  AW  register address, valid during reg_we_o / reg_re_o
reg_wdata_o  output  8  write data, valid with reg_we_o
reg_we_o  output  1  one-cycle write strobe
reg_re_o  output  1  one-cycle read strobe
reg_rdata_i  input  8  read data; sampled the cycle after reg_re_o
fifo_rd_o  output  1  one-cycle FIFO pop strobe (feature-gated)
fifo_data_i  input  8  FIFO data; sampled the cycle after fifo_rd_o
busy_o  output  1  transaction in progress (synchronized ncs low)

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, reg_addr_o=0, reg_wdata_o=0, reg_we_o=0, reg_re_o=0, fifo_rd_o=0, busy_o=0. FSM resets to IDLE and the bit counter to 0.
- Input synchronization: SYNC_STAGES flops on each pin, then registered edge detection on sclk.
  - Sample mosi on the sclk rising edge.
  - Shift miso on the sclk falling edge.
  - Latency from a pin edge to internal detection is SYNC_STAGES+1 cycles.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, FDATA, IGNORE.
  - IDLE -> CMD on ncs falling.
  - CMD: after 8 bits, decode the command.
    - 0x0A or 0x0B -> ADDR.
    - 0x0D -> FDATA (feature on).
    - Any other value -> IGNORE.
  - ADDR: after 8 bits, load the address counter; AW < 8 uses the low AW bits.
    - Write command -> WDATA.
    - Read command -> pulse reg_re_o with reg_addr_o = address, then go to RDATA.
  - WDATA: after each 8th bit, pulse reg_we_o with the current address and byte, then increment the address.
  - RDATA: the byte latched from reg_rdata_i is loaded into the TX shift register.
    - Its MSB appears on miso_o at the first sclk falling edge after the last address bit.
    - After each 8th rising edge: increment the address, pulse reg_re_o for the next byte, and reload at the following falling edge.
  - FDATA: same as RDATA, but fifo_rd_o / fifo_data_i are used and there is no address.
    - The first pop occurs 1 cycle after command decode.
  - IGNORE: no bus strobes; miso_o=0 until ncs rises.
- miso_o outside RDATA/FDATA is 0.
- Address wrap: address (2^AW)-1 increments to 0.
- ncs rising in any state returns the FSM to IDLE within SYNC_STAGES+1 cycles.
  - A partial byte is discarded: no we/re strobe.
  - The bit counter is cleared.
- A read-ahead strobe already issued for a byte that never gets clocked out is permitted; the FIFO therefore loses that entry, matching ADXL362 behaviour.
- reg_we_o and reg_re_o are never high in the same cycle.
- At most one strobe per byte boundary.
- Reset asserted mid-transaction clears everything immediately.
  - After reset release with ncs still low, the block stays in IGNORE until ncs goes high.
- sclk edges seen while ncs is high are ignored.

Optional Feature:
SPI_REG_SLAVE_FIFO_READ_EN
- Defined: command 0x0D is decoded to FDATA and fifo_rd_o is functional.
- Undefined: 0x0D is treated as an unknown command (-> IGNORE), fifo_rd_o is tied to 0, and fifo_data_i is unused. The ports exist in both builds.

Test Plan:
- Burst write: ncs low, bytes 0x0A,0x20,0x5A,0xA5 -> reg_we_o pulses with addr 0x20 data 0x5A, then addr 0x21 data 0xA5. Exactly 2 strobes, no reg_re_o.
- Burst read: bytes 0x0B,0x00,0x00,0x00; bank returns 0xAD@0x00, 0x1D@0x01 -> MISO bytes 3-4 read back 0xAD, 0x1D. reg_re_o pulses at addr 0x00, 0x01, 0x02.
- Wrap: read from addr 0xFF for 2 bytes (AW=8) -> reg_re_o at 0xFF then 0x00; MISO returns both values.
- Abort: write 0x0A,0x10, then 4 data bits, then ncs high -> no reg_we_o. A following full write to 0x11 of 0x33 -> one strobe at addr 0x11, data 0x33.
- Unknown command 0x55 followed by 3 bytes -> no strobes; miso_o=0 throughout; busy_o falls after ncs rises.
- FIFO (macro defined): bytes 0x0D + 2 dummy bytes; fifo_data_i sequence 0x01,0x02 -> MISO 0x01, 0x02. With the macro undefined -> MISO 0x00, 0x00 and fifo_rd_o stays 0. Also assert rst_i low mid-read -> all outputs return to reset values.
